// File: rtl/mem_arb_pkg.sv
// Shared constants and encodings for the memory port arbiter.
// Size codes follow the RISC-V load/store func3 field.
package mem_arb_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_req_check.sv
// Legality check for one memory request: range, size code and
// natural alignment. Purely combinational.
module mem_req_check
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 65536
) (
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_func3,
    input  logic        i_write,
    input  logic        i_is_fetch,
    output logic        o_legal
);

    localparam logic [32:0] LP_LIMIT = 33'(MEM_SIZE);

    logic w_in_range;
    logic w_size_ok;
    logic w_align_ok;

    assign w_in_range = {1'b0, i_addr} < LP_LIMIT;

    // Size code and alignment rules; stores may not use BU/HU.
    always_comb begin
        w_size_ok  = 1'b0;
        w_align_ok = 1'b0;
        if (i_is_fetch) begin
            w_size_ok  = 1'b1;
            w_align_ok = (i_addr[1:0] == 2'b00);
        end else begin
            case (i_func3)
                F3_B, F3_BU: begin
                    w_size_ok  = (i_func3 == F3_B) || !i_write;
                    w_align_ok = 1'b1;
                end
                F3_H, F3_HU: begin
                    w_size_ok  = (i_func3 == F3_H) || !i_write;
                    w_align_ok = !i_addr[0];
                end
                F3_W: begin
                    w_size_ok  = 1'b1;
                    w_align_ok = (i_addr[1:0] == 2'b00);
                end
                default: begin
                    w_size_ok  = 1'b0;
                    w_align_ok = 1'b0;
                end
            endcase
        end
    end

    assign o_legal = w_in_range & w_size_ok & w_align_ok;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of the single-port memory between fetch and
// load/store, with one-cycle read sequencing and request checking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_req_addr,
    input  logic [2:0]  ls_req_func3,
    input  logic        ls_req_write,
    input  logic [31:0] ls_req_wdata,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        ls_rsp_err,
    output logic [31:0] mem_address,
    output logic [2:0]  mem_func3,
    output logic        mem_write_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    state_t r_state;
    owner_t r_owner;
    owner_t r_last_grant;
    logic   r_err_q;
    logic   r_store;

    logic        w_idle;
    logic        w_wait;
    logic        w_gnt_if;
    logic        w_gnt_ls;
    logic        w_grant;
    logic        w_legal;
    logic        w_write;
    logic [31:0] w_addr;
    logic [2:0]  w_func3;
    logic [31:0] w_rsp_data;

    assign w_idle = !reset && (r_state == ST_IDLE);
    assign w_wait = !reset && (r_state == ST_WAIT);

    // On contention the side that did not win last time goes first.
    assign w_gnt_ls = w_idle && ls_req_valid
                   && (!if_req_valid || r_last_grant == OWN_IF);
    assign w_gnt_if = w_idle && if_req_valid && !w_gnt_ls;
    assign w_grant  = w_gnt_if | w_gnt_ls;

    assign w_addr  = w_gnt_ls ? ls_req_addr : if_req_addr;
    assign w_func3 = w_gnt_ls ? ls_req_func3 : F3_W;
    assign w_write = w_gnt_ls & ls_req_write;

    mem_req_check #(
        .MEM_SIZE(MEM_SIZE)
    ) u_check (
        .i_addr    (w_addr),
        .i_func3   (w_func3),
        .i_write   (w_write),
        .i_is_fetch(!w_gnt_ls),
        .o_legal   (w_legal)
    );

    assign if_req_ready = w_gnt_if;
    assign ls_req_ready = w_gnt_ls;

    assign mem_address  = (w_grant && w_legal) ? w_addr : 32'h0;
    assign mem_func3    = w_func3;
    assign mem_write_en = w_write & w_legal;
    assign mem_data_in  = w_gnt_ls ? ls_req_wdata : 32'h0;

    assign w_rsp_data = (r_err_q || r_store) ? 32'h0 : mem_data_out;

    assign if_rsp_valid = w_wait && (r_owner == OWN_IF);
    assign ls_rsp_valid = w_wait && (r_owner == OWN_LS);
    assign if_rsp_err   = if_rsp_valid & r_err_q;
    assign ls_rsp_err   = ls_rsp_valid & r_err_q;
    assign if_rsp_data  = if_rsp_valid ? w_rsp_data : 32'h0;
    assign ls_rsp_data  = ls_rsp_valid ? w_rsp_data : 32'h0;

    // Grant capture in IDLE, unconditional return from WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_last_grant <= OWN_IF;
            r_err_q      <= 1'b0;
            r_store      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state      <= ST_WAIT;
                        r_owner      <= w_gnt_ls ? OWN_LS : OWN_IF;
                        r_last_grant <= w_gnt_ls ? OWN_LS : OWN_IF;
                        r_err_q      <= !w_legal;
                        r_store      <= w_write;
                    end
                end
                ST_WAIT: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
